// File: rtl/uart_rx_param_core.sv
// Oversampling UART receiver with a single held output word and error flags.
// Optional parity bit and check are compiled in by defining UART_RX_PARITY_EN.
module uart_rx_param_core #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUDRATE   = 9600,
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 rd_ack,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 rx_done_tick,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err
);

    localparam int DIV_RAW = CLK_FREQ / (BAUDRATE * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW      = $clog2(OVERSAMPLE);
    localparam int NW      = $clog2(DATA_BITS + 1);

    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [SW-1:0] MID_TICK  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] BIT_TICK  = SW'(OVERSAMPLE - 1);
    localparam logic [NW-1:0] DATA_LAST = NW'(DATA_BITS - 1);
    localparam logic [NW-1:0] STOP_LAST = NW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    logic                 rx_meta_q;
    logic                 rx_sync_q;
    logic                 rx_prev_q;

    logic [DW-1:0]        div_cnt_q, div_cnt_d;
    logic                 tick;

    state_e               state_q, state_d;
    logic [SW-1:0]        s_cnt_q, s_cnt_d;
    logic [NW-1:0]        n_cnt_q, n_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 stop_err_q, stop_err_d;
    logic                 frame_done;
    logic                 frame_err_new;

    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;

`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d;
    logic                 perr_q, perr_d;
`endif

    // Synchroniser and edge-detect history reset to the idle-high line level
    // so that leaving reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep each stage one clock apart.
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign tick      = (div_cnt_q == DIV_LAST);
    assign div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;

    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        state_d       = state_q;
        s_cnt_d       = s_cnt_q;
        n_cnt_d       = n_cnt_q;
        shift_d       = shift_q;
        stop_err_d    = stop_err_q;
        frame_done    = 1'b0;
        frame_err_new = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d     = par_bad_q;
`endif

        case (state_q)
            IDLE: begin
                // Only a falling edge starts a frame; a held-low break does not.
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = START;
                    s_cnt_d = '0;
                end
            end

            START: begin
                if (tick) begin
                    if (s_cnt_q == MID_TICK) begin
                        if (!rx_sync_q) begin
                            state_d = DATA;
                            s_cnt_d = '0;
                            n_cnt_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end

            DATA: begin
                if (tick) begin
                    if (s_cnt_q == BIT_TICK) begin
                        s_cnt_d = '0;
                        shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};
                        if (n_cnt_q == DATA_LAST) begin
                            n_cnt_d    = '0;
                            stop_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                            state_d    = PARITY;
`else
                            state_d    = STOP;
`endif
                        end else begin
                            n_cnt_d = n_cnt_q + 1'b1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end

            PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (tick) begin
                    if (s_cnt_q == BIT_TICK) begin
                        s_cnt_d   = '0;
                        // Mismatch when data plus parity bit has the wrong ones-count parity.
                        par_bad_d = (^shift_q) ^ rx_sync_q ^ (PARITY_ODD != 0);
                        state_d   = STOP;
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
`else
                state_d = IDLE;
`endif
            end

            STOP: begin
                if (tick) begin
                    if (s_cnt_q == BIT_TICK) begin
                        s_cnt_d = '0;
                        if (!rx_sync_q) begin
                            stop_err_d = 1'b1;
                        end
                        if (n_cnt_q == STOP_LAST) begin
                            frame_done    = 1'b1;
                            frame_err_new = stop_err_q | ~rx_sync_q;
                            n_cnt_d       = '0;
                            state_d       = IDLE;
                        end else begin
                            n_cnt_d = n_cnt_q + 1'b1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;
        done_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d  = perr_q;
`endif

        // Completion wins over acknowledge; a same-cycle ack consumes the old word.
        if (frame_done) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            ferr_d  = frame_err_new;
            ovr_d   = valid_q & ~rd_ack;
            done_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_d  = par_bad_q;
`endif
        end else if (rd_ack && valid_q) begin
            valid_d = 1'b0;
            ferr_d  = 1'b0;
            ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q  <= '0;
            state_q    <= IDLE;
            s_cnt_q    <= '0;
            n_cnt_q    <= '0;
            shift_q    <= '0;
            stop_err_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            div_cnt_q  <= div_cnt_d;
            state_q    <= state_d;
            s_cnt_q    <= s_cnt_d;
            n_cnt_q    <= n_cnt_d;
            shift_q    <= shift_d;
            stop_err_q <= stop_err_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= par_bad_d;
            perr_q     <= perr_d;
`endif
        end
    end

    assign data_out     = data_q;
    assign data_valid   = valid_q;
    assign rx_done_tick = done_q;
    assign frame_err    = ferr_q;
    assign overrun_err  = ovr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err   = perr_q;
`else
    assign parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param_core.sv
// Scoreboard bench for uart_rx_param_core: directed frames push expected words,
// a monitor pops and compares on every rx_done_tick.
module tb_uart_rx_param_core;

    localparam int CLK_FREQ   = 1600000;
    localparam int BAUDRATE   = 10000;
    localparam int OVERSAMPLE = 16;
    localparam int BIT_CLKS   = 160;

    typedef struct {
        logic [7:0] data;
        logic       fe;
        logic       pe;
        logic       ov;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       rd_ack;
    logic [7:0] data_out;
    logic       data_valid;
    logic       rx_done_tick;
    logic       frame_err;
    logic       parity_err;
    logic       overrun_err;

    exp_t exp_q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   done_seen = 0;
    int   n_expect  = 0;
    logic done_prev = 1'b0;

    uart_rx_param_core #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUDRATE  (BAUDRATE),
        .DATA_BITS (8),
        .OVERSAMPLE(OVERSAMPLE),
        .STOP_BITS (1),
        .PARITY_ODD(0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .rd_ack      (rd_ack),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .rx_done_tick(rx_done_tick),
        .frame_err   (frame_err),
        .parity_err  (parity_err),
        .overrun_err (overrun_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic fe, input logic pe, input logic ov);
        exp_t e;
        e.data = d;
        e.fe   = fe;
        e.pe   = pe;
        e.ov   = ov;
        exp_q.push_back(e);
        n_expect++;
    endtask

    task automatic drive_bit(input logic b);
        @(negedge clk);
        rx = b;
        repeat (BIT_CLKS - 1) @(negedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // par_good selects a correct even-parity bit or its inverse.
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_good);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_good ? ^d : ~^d);
`else
        if (par_good) begin end
`endif
        drive_bit(stop_v);
    endtask

    task automatic ack();
        @(negedge clk);
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_valid"}, data_valid, 0);
        check({tag, "_ferr"}, frame_err, 0);
        check({tag, "_perr"}, parity_err, 0);
        check({tag, "_ovr"}, overrun_err, 0);
    endtask

    // Monitor: compares the held word against the scoreboard on each completion.
    always @(negedge clk) begin
        if (done_prev) check("done_pulse_width", rx_done_tick, 0);
        if (rx_done_tick && !done_prev) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame: got data 0x%0h expected no frame", data_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("frame_data", data_out, e.data);
                check("frame_valid", data_valid, 1);
                check("frame_ferr", frame_err, e.fe);
                check("frame_perr", parity_err, e.pe);
                check("frame_ovr", overrun_err, e.ov);
            end
        end
        done_prev = rx_done_tick;
    end

    initial begin
        reset  = 1'b1;
        rx     = 1'b1;
        rd_ack = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_data", data_out, 0);
        check("rst_done", rx_done_tick, 0);
        check_cleared("rst");
        reset = 1'b0;
        idle(50);

        // 0x55 8N1, left unread.
        expect_frame(8'h55, 1'b0, 1'b0, 1'b0);
        send_frame(8'h55, 1'b1, 1'b1);
        idle(200);
        check("hold_valid", data_valid, 1);
        check("hold_data", data_out, 8'h55);
        ack();
        check_cleared("ack1");

        // Short low glitch: START rejects it.
        @(negedge clk);
        rx = 1'b0;
        repeat (40) @(negedge clk);
        idle(400);
        check("glitch_valid", data_valid, 0);
        check("glitch_frames", done_seen, n_expect);

        // Stop bit 0 then a long break: one frame with frame_err, no retrigger.
        expect_frame(8'hA3, 1'b1, 1'b0, 1'b0);
        send_frame(8'hA3, 1'b0, 1'b1);
        repeat (2000) @(negedge clk);
        idle(300);
        check("break_frames", done_seen, n_expect);
        check("break_ferr", frame_err, 1);
        ack();
        check_cleared("ack2");

        // Two unread frames: second overwrites and flags overrun.
        expect_frame(8'h12, 1'b0, 1'b0, 1'b0);
        send_frame(8'h12, 1'b1, 1'b1);
        idle(200);
        expect_frame(8'h34, 1'b0, 1'b0, 1'b1);
        send_frame(8'h34, 1'b1, 1'b1);
        idle(200);
        check("ovr_data", data_out, 8'h34);
        check("ovr_flag", overrun_err, 1);
        ack();
        check_cleared("ack3");

`ifdef UART_RX_PARITY_EN
        expect_frame(8'h07, 1'b0, 1'b1, 1'b0);
        send_frame(8'h07, 1'b1, 1'b0);
        idle(200);
        ack();
        expect_frame(8'h07, 1'b0, 1'b0, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1);
        idle(200);
        ack();
`endif

        // Leave 0xFF unread, then reset after the 3rd data bit of a new frame.
        expect_frame(8'hFF, 1'b0, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b1);
        idle(200);
        check("pre_rst_valid", data_valid, 1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        @(negedge clk);
        reset = 1'b1;
        rx    = 1'b1;
        @(negedge clk);
        check("midrst_data", data_out, 0);
        check("midrst_done", rx_done_tick, 0);
        check_cleared("midrst");
        reset = 1'b0;
        idle(2000);
        check("midrst_frames", done_seen, n_expect);

        expect_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b1, 1'b1);
        idle(300);
        check("final_data", data_out, 8'h5A);

        check("frames_seen", done_seen, n_expect);
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_param_core.md
UART_RX_PARAM_CORE -- requirements
Module: uart_rx_param_core

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000: input clock frequency in Hz.
REQ-002 SHALL have parameter BAUDRATE, default 9600: line bit rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, legal range 5..9: data bits per frame.
REQ-004 SHALL have parameter OVERSAMPLE, default 16, legal values 8 or 16: sample ticks per bit.
REQ-005 SHALL have parameter STOP_BITS, default 1, legal values 1 or 2: stop bits checked per frame.
REQ-006 SHALL have parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd; it is used only when UART_RX_PARITY_EN is defined.
REQ-007 SHALL have port clk, input, width 1: the single clock.
REQ-008 SHALL have port reset, input, width 1: synchronous, active-high reset.
REQ-009 SHALL have port rx, input, width 1: asynchronous serial line that idles high.
REQ-010 SHALL have port rd_ack, input, width 1: consumer acknowledge for the held word.
REQ-011 SHALL have port data_out, output, width DATA_BITS: last received word.
REQ-012 SHALL have port data_valid, output, width 1: data_out holds an unread word.
REQ-013 SHALL have port rx_done_tick, output, width 1: one-cycle pulse when a frame completes.
REQ-014 SHALL have port frame_err, output, width 1: a stop bit of the held word was sampled 0.
REQ-015 SHALL have port parity_err, output, width 1: parity mismatch on the held word.
REQ-016 SHALL have port overrun_err, output, width 1: a word was overwritten while unread.

Function
REQ-017 SHALL synchronise rx through two flip-flops before any use; all rx references below mean the synchronised signal.
REQ-018 SHALL generate an internal sample tick that is high for one clk every DIV = floor(CLK_FREQ/(BAUDRATE*OVERSAMPLE)) cycles; the tick divider is free-running.
REQ-019 SHALL use FSM states IDLE, START, DATA, PARITY and STOP, all registered.
REQ-020 IDLE SHALL move to START on a 1->0 transition of rx and clear the tick counter; a line held low (break) SHALL NOT retrigger START.
REQ-021 START SHALL sample rx at tick OVERSAMPLE/2-1: rx=0 moves to DATA with counters cleared, rx=1 (glitch) returns to IDLE with no output change.
REQ-022 DATA SHALL sample rx every OVERSAMPLE ticks, shift it in LSB first, and after DATA_BITS samples move to PARITY when parity is compiled in, else to STOP.
REQ-023 PARITY SHALL sample one bit after OVERSAMPLE ticks and compute the mismatch against the data word using PARITY_ODD.
REQ-024 STOP SHALL sample STOP_BITS bits at OVERSAMPLE-tick spacing; any sampled 0 SHALL record a framing error.
REQ-025 On the edge that processes the final stop sample, SHALL load data_out, frame_err and parity_err, set data_valid, pulse rx_done_tick for exactly one cycle, and return to IDLE.
REQ-026 rd_ack with data_valid=1 SHALL clear data_valid, frame_err, parity_err and overrun_err on the next edge; rd_ack with data_valid=0 SHALL be ignored.
REQ-027 Frame completion while data_valid=1 and rd_ack=0 SHALL overwrite data_out and set overrun_err=1.
REQ-028 Frame completion and rd_ack in the same cycle SHALL store the new word with data_valid=1 and overrun_err=0.
REQ-029 Frame latency SHALL be 2 clk (synchroniser) plus sample timing; no other added pipeline stage is permitted.

Reset
REQ-030 reset SHALL, on the next clk edge, put the FSM in IDLE and clear the tick divider, all counters, the shift register, data_out, data_valid, rx_done_tick and all error flags to 0.
REQ-031 The synchroniser SHALL reset to 1 (line idle).
REQ-032 reset mid-frame SHALL discard the partial frame; reset SHALL take priority over rd_ack and frame completion.

Configuration
REQ-033 With macro UART_RX_PARITY_EN defined, the PARITY state and parity check SHALL be present.
REQ-034 Without UART_RX_PARITY_EN, the frame SHALL have no parity bit, DATA SHALL go directly to STOP, and parity_err SHALL be tied to 0.

Verification (bench parameters CLK_FREQ=1600000, BAUDRATE=10000, OVERSAMPLE=16, giving DIV=10 and 160 clk per bit)
REQ-035 Send 0x55 as 8N1, then hold rd_ack=0 -> rx_done_tick high for 1 cycle, data_out=0x55, data_valid=1, all error flags 0.
REQ-036 Drive rx low for 40 clk, then high -> no rx_done_tick, data_valid stays 0, FSM back in IDLE.
REQ-037 Send 0xA3 with the stop bit driven 0 -> data_out=0xA3, frame_err=1; keep rx low for 2000 clk -> no further rx_done_tick.
REQ-038 Send 0x12 then 0x34 with no rd_ack -> data_out=0x34, overrun_err=1; then pulse rd_ack -> data_valid=0 and all flags 0.
REQ-039 With UART_RX_PARITY_EN defined and PARITY_ODD=0, send 0x07 with parity bit 0 -> parity_err=1; send 0x07 with parity bit 1 -> parity_err=0.
REQ-040 Assert reset after the 3rd data bit of a frame -> all outputs 0 on the next edge; then send 0x5A -> data_out=0x5A with no error flags.
